countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Falling-edge BCD mm:ss countdown timer with IDLE/RUN/PAUSE/DONE control,
// sanitised preset load and a tick-counted alarm pulse after expiry.
module countdown_timer #(
  parameter int unsigned ALARM_LEN = 10
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       Tick1Hz,
  input  logic       Load,
  input  logic [3:0] SetMH,
  input  logic [3:0] SetML,
  input  logic [3:0] SetSH,
  input  logic [3:0] SetSL,
  input  logic       Start,
  input  logic       Pause,
  output logic [3:0] MinH,
  output logic [3:0] MinL,
  output logic [3:0] SecH,
  output logic [3:0] SecL,
  output logic       Running,
  output logic       Done,
  output logic       Alarm
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] mh_q, mh_d, ml_q, ml_d, sh_q, sh_d, sl_q, sl_d;
  logic       run_q, run_d, done_q, done_d, alarm_q, alarm_d;
  logic [7:0] acnt_q, acnt_d;

  logic [3:0] dec_mh, dec_ml, dec_sh, dec_sl;
  logic       b0, b1, b2;
  logic       cnt_zero, cnt_one;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second borrow chain; digits are always valid BCD so no range checks needed.
  always_comb begin
    b0     = (sl_q == 4'd0);
    dec_sl = b0 ? 4'd9 : sl_q - 4'd1;
    b1     = b0 && (sh_q == 4'd0);
    dec_sh = b0 ? ((sh_q == 4'd0) ? 4'd5 : sh_q - 4'd1) : sh_q;
    b2     = b1 && (ml_q == 4'd0);
    dec_ml = b1 ? ((ml_q == 4'd0) ? 4'd9 : ml_q - 4'd1) : ml_q;
    dec_mh = b2 ? mh_q - 4'd1 : mh_q;
  end

  assign cnt_zero = (mh_q == 4'd0) && (ml_q == 4'd0) && (sh_q == 4'd0) && (sl_q == 4'd0);
  assign cnt_one  = (mh_q == 4'd0) && (ml_q == 4'd0) && (sh_q == 4'd0) && (sl_q == 4'd1);

  always_comb begin
    state_d = state_q;
    mh_d    = mh_q;
    ml_d    = ml_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    alarm_d = alarm_q;
    acnt_d  = acnt_q;

    if (Load) begin
      state_d = S_IDLE;
      mh_d    = clamp(SetMH, 4'd9);
      ml_d    = clamp(SetML, 4'd9);
      sh_d    = clamp(SetSH, 4'd5);
      sl_d    = clamp(SetSL, 4'd9);
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (Start && !cnt_zero) state_d = S_RUN;
        S_RUN: begin
          if (Pause) begin
            state_d = S_PAUSE;
          end else if (Tick1Hz) begin
            mh_d = dec_mh;
            ml_d = dec_ml;
            sh_d = dec_sh;
            sl_d = dec_sl;
            if (cnt_one) begin
              state_d = S_DONE;
              alarm_d = 1'b1;
              acnt_d  = '0;
            end
          end
        end
        S_PAUSE: if (Start) state_d = S_RUN;
        S_DONE: begin
          // Counter stops once the alarm has dropped; Done persists until Load.
          if (Tick1Hz && alarm_q) begin
            acnt_d = acnt_q + 8'd1;
            if (acnt_d == 8'(ALARM_LEN)) alarm_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    run_d  = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(negedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= S_IDLE;
      mh_q    <= '0;
      ml_q    <= '0;
      sh_q    <= '0;
      sl_q    <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mh_q    <= mh_d;
      ml_q    <= ml_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      run_q   <= run_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign MinH    = mh_q;
  assign MinL    = ml_q;
  assign SecH    = sh_q;
  assign SecL    = sl_q;
  assign Running = run_q;
  assign Done    = done_q;
  assign Alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_countdown_timer;

  localparam int AL = 10;

  logic       CP = 1'b0;
  logic       nCR = 1'b1;
  logic       Tick1Hz = 1'b0, Load = 1'b0, Start = 1'b0, Pause = 1'b0;
  logic [3:0] SetMH = '0, SetML = '0, SetSH = '0, SetSL = '0;
  logic [3:0] MinH, MinL, SecH, SecL;
  logic       Running, Done, Alarm;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.ALARM_LEN(AL)) dut (
    .CP(CP), .nCR(nCR), .Tick1Hz(Tick1Hz), .Load(Load),
    .SetMH(SetMH), .SetML(SetML), .SetSH(SetSH), .SetSL(SetSL),
    .Start(Start), .Pause(Pause),
    .MinH(MinH), .MinL(MinL), .SecH(SecH), .SecL(SecL),
    .Running(Running), .Done(Done), .Alarm(Alarm)
  );

  always #5 CP = ~CP;

  // Reference model: remaining time in seconds, mode 0 idle, 1 run, 2 pause, 3 done.
  int m_secs = 0;
  int m_mode = 0;
  int m_dt   = 0;

  function automatic int lim(input logic [3:0] d, input int l);
    return (int'(d) > l) ? l : int'(d);
  endfunction

  function automatic logic [15:0] bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  always @(negedge CP or negedge nCR) begin
    if (!nCR) begin
      m_secs = 0; m_mode = 0; m_dt = 0;
    end else if (Load) begin
      m_secs = (lim(SetMH, 9) * 10 + lim(SetML, 9)) * 60 + lim(SetSH, 5) * 10 + lim(SetSL, 9);
      m_mode = 0; m_dt = 0;
    end else begin
      case (m_mode)
        0: if (Start && m_secs != 0) m_mode = 1;
        1: if (Pause) m_mode = 2;
           else if (Tick1Hz) begin
             m_secs = m_secs - 1;
             if (m_secs == 0) begin m_mode = 3; m_dt = 0; end
           end
        2: if (Start) m_mode = 1;
        default: if (Tick1Hz && m_dt < AL) m_dt = m_dt + 1;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CP) begin
    chk("model count", {MinH, MinL, SecH, SecL}, bcd(m_secs));
    chk("model flags", {13'b0, Running, Done, Alarm},
        {13'b0, m_mode == 1, m_mode == 3, (m_mode == 3) && (m_dt < AL)});
  end

  task automatic drive(input logic tk, ld, st, ps);
    @(posedge CP); #1;
    Tick1Hz = tk; Load = ld; Start = st; Pause = ps;
  endtask

  task automatic load(input logic [3:0] a, b, c, d);
    SetMH = a; SetML = b; SetSH = c; SetSL = d;
    drive(0, 1, 0, 0);
  endtask

  task automatic lit(input string nm, input logic [15:0] cnt, input logic r, d, a);
    @(negedge CP); #2;
    chk({nm, " cnt"}, {MinH, MinL, SecH, SecL}, cnt);
    chk({nm, " flags"}, {13'b0, Running, Done, Alarm}, {13'b0, r, d, a});
  endtask

  initial begin
    #2 nCR = 1'b0;
    #1;
    chk("reset cnt", {MinH, MinL, SecH, SecL}, 16'h0000);
    chk("reset flags", {13'b0, Running, Done, Alarm}, 16'h0000);
    @(posedge CP); #1 nCR = 1'b1;

    // Preset sanitising and zero-start rejection
    load(4'd0, 4'd0, 4'd7, 4'd12);   lit("sanitise", 16'h0059, 0, 0, 0);
    load(4'd12, 4'd15, 4'd9, 4'd10); lit("sanitise max", 16'h9959, 0, 0, 0);
    load(4'd0, 4'd0, 4'd0, 4'd0);    lit("load zero", 16'h0000, 0, 0, 0);
    drive(0, 0, 1, 0);               lit("start at zero", 16'h0000, 0, 0, 0);

    // 00:03 run to expiry, then alarm length
    load(4'd0, 4'd0, 4'd0, 4'd3);
    drive(1, 0, 1, 0);               lit("start no dec", 16'h0003, 1, 0, 0);
    drive(1, 0, 0, 0);               lit("tick1", 16'h0002, 1, 0, 0);
    drive(1, 0, 0, 0);               lit("tick2", 16'h0001, 1, 0, 0);
    drive(1, 0, 0, 0);               lit("expire", 16'h0000, 0, 1, 1);
    for (int k = 1; k <= AL; k++) begin
      drive(1, 0, 1, 1);             lit("alarm tick", 16'h0000, 0, 1, k < AL);
      drive(0, 0, 0, 0);
    end
    drive(1, 0, 0, 0);               lit("alarm stays off", 16'h0000, 0, 1, 0);
    load(4'd0, 4'd1, 4'd0, 4'd0);    lit("reload 01:00", 16'h0100, 0, 0, 0);

    // Full borrow chain
    load(4'd1, 4'd0, 4'd0, 4'd0);
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);               lit("borrow chain", 16'h0959, 1, 0, 0);

    // Pause priority and resume
    load(4'd0, 4'd0, 4'd0, 4'd6);
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);               lit("to 00:05", 16'h0005, 1, 0, 0);
    drive(1, 0, 1, 1);               lit("pause wins", 16'h0005, 0, 0, 0);
    repeat (3) begin drive(1, 0, 0, 0); lit("paused tick", 16'h0005, 0, 0, 0); end
    drive(1, 0, 1, 0);               lit("resume no dec", 16'h0005, 1, 0, 0);
    drive(1, 0, 0, 0);               lit("resumed tick", 16'h0004, 1, 0, 0);

    // Async reset mid-run
    load(4'd0, 4'd5, 4'd3, 4'd0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);               lit("run 05:30", 16'h0530, 1, 0, 0);
    @(posedge CP); #2 nCR = 1'b0;
    #1;
    chk("async rst cnt", {MinH, MinL, SecH, SecL}, 16'h0000);
    chk("async rst flags", {13'b0, Running, Done, Alarm}, 16'h0000);
    @(posedge CP); #1 nCR = 1'b1;

    // Randomized phase, mostly short presets so expiry and alarm are exercised
    repeat (3000) begin
      @(posedge CP); #1;
      nCR     = ($urandom_range(0, 399) != 0);
      Tick1Hz = ($urandom_range(0, 2) == 0);
      Load    = ($urandom_range(0, 39) == 0);
      Start   = ($urandom_range(0, 5) == 0);
      Pause   = ($urandom_range(0, 9) == 0);
      if (Load) begin
        SetMH = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        SetML = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        SetSH = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        SetSL = 4'($urandom_range(0, 15));
      end
    end
    drive(0, 0, 0, 0);
    nCR = 1'b1;
    repeat (4) @(posedge CP);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
